// File: rtl/mem_responder.sv
// Unified instruction/data memory responder: 1-cycle fetch port plus a wait-state data read FSM.
// Define MEM_ALIGN_CHECK_EN to enable sticky protocol checking on err_o.
module mem_responder #(
    parameter int unsigned ADDR_WIDTH   = 14,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        instr_read_i,
    input  logic [31:0] instr_addr_i,
    output logic [31:0] instr_out_o,
    output logic        instr_valid_o,
    input  logic        data_read_i,
    input  logic [31:0] data_addr_i,
    input  logic [3:0]  data_write_i,
    input  logic [31:0] data_in_i,
    output logic [31:0] data_out_o,
    output logic        data_valid_o,
    output logic        err_o
);

    localparam int unsigned Depth = 2 ** ADDR_WIDTH;
    // Wait count loaded on accept; D_WAIT spends WaitInit+1 cycles before D_RESP.
    localparam logic [3:0] WaitInit = (READ_LATENCY > 1) ? 4'(READ_LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {StIdle, StWait, StResp} d_state_e;

    logic [31:0]           mem_q [Depth];
    logic [ADDR_WIDTH-1:0] iidx;
    logic [ADDR_WIDTH-1:0] didx;
    logic [ADDR_WIDTH-1:0] ridx_q, ridx_d;
    d_state_e              state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [31:0]           instr_out_q, instr_out_d;
    logic                  instr_valid_q, instr_valid_d;
    logic [31:0]           data_out_q, data_out_d;
    logic                  data_valid_q, data_valid_d;
    logic                  wr_legal;
    logic                  wr_en;
    logic                  rd_with_wr;

    assign iidx = instr_addr_i[ADDR_WIDTH+1:2];
    assign didx = data_addr_i[ADDR_WIDTH+1:2];

    // Upper address bits alias; byte offset bits never select a word.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{instr_addr_i[31:ADDR_WIDTH+2], instr_addr_i[1:0],
                                data_addr_i[31:ADDR_WIDTH+2], data_addr_i[1:0]};

    always_comb begin
        wr_legal = 1'b1;
`ifdef MEM_ALIGN_CHECK_EN
        case (data_write_i)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b0110, 4'b1100, 4'b1111: wr_legal = 1'b1;
            default:                            wr_legal = 1'b0;
        endcase
`endif
    end

    assign wr_en = (data_write_i != 4'b0000) && wr_legal;

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (data_write_i[i]) begin
                    mem_q[didx][8*i +: 8] <= data_in_i[8*i +: 8];
                end
            end
        end
    end

    // Fetch reads mem_q before this edge's write lands, so it sees the pre-write word.
    always_comb begin
        instr_valid_d = instr_read_i;
        instr_out_d   = instr_out_q;
        if (instr_read_i) begin
            instr_out_d = mem_q[iidx];
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ridx_d       = ridx_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        rd_with_wr   = 1'b0;
        case (state_q)
            StIdle: begin
                if (data_read_i) begin
                    if (data_write_i == 4'b0000) begin
                        ridx_d = didx;
                        if (READ_LATENCY == 1) begin
                            state_d = StResp;
                        end else begin
                            cnt_d   = WaitInit;
                            state_d = StWait;
                        end
                    end else begin
                        rd_with_wr = 1'b1;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                data_out_d   = mem_q[ridx_q];
                data_valid_d = 1'b1;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            cnt_q         <= 4'd0;
            ridx_q        <= '0;
            instr_out_q   <= 32'h0;
            instr_valid_q <= 1'b0;
            data_out_q    <= 32'h0;
            data_valid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ridx_q        <= ridx_d;
            instr_out_q   <= instr_out_d;
            instr_valid_q <= instr_valid_d;
            data_out_q    <= data_out_d;
            data_valid_q  <= data_valid_d;
        end
    end

    assign instr_out_o   = instr_out_q;
    assign instr_valid_o = instr_valid_q;
    assign data_out_o    = data_out_q;
    assign data_valid_o  = data_valid_q;

`ifdef MEM_ALIGN_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if ((data_write_i != 4'b0000) && !wr_legal) begin
            err_d = 1'b1;
        end
        if (instr_read_i && (instr_addr_i[1:0] != 2'b00)) begin
            err_d = 1'b1;
        end
        if (rd_with_wr) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    logic unused_rd_with_wr;
    assign unused_rd_with_wr = rd_with_wr;
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (latency 1, 3, 4) share stimulus and are checked
// against directed constants and a transaction-level memory/latency model.
`timescale 1ns/1ps
module tb_mem_responder;

    localparam int AW   = 14;
    localparam int NDUT = 3;
`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        instr_read;
    logic [31:0] instr_addr;
    logic        data_read;
    logic [31:0] data_addr;
    logic [3:0]  data_write;
    logic [31:0] data_in;

    logic [31:0] io   [NDUT];
    logic        iv   [NDUT];
    logic [31:0] dout [NDUT];
    logic        dv   [NDUT];
    logic        er   [NDUT];

    int n_checks;
    int n_errors;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        mem_responder #(
            .ADDR_WIDTH  (AW),
            .READ_LATENCY((g == 0) ? 1 : ((g == 1) ? 3 : 4))
        ) u_dut (
            .clk_i        (clk),
            .rst_ni       (rst_n),
            .instr_read_i (instr_read),
            .instr_addr_i (instr_addr),
            .instr_out_o  (io[g]),
            .instr_valid_o(iv[g]),
            .data_read_i  (data_read),
            .data_addr_i  (data_addr),
            .data_write_i (data_write),
            .data_in_i    (data_in),
            .data_out_o   (dout[g]),
            .data_valid_o (dv[g]),
            .err_o        (er[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: word-addressed memory, reads scheduled by absolute edge number.
    logic [31:0] mm [int];
    int          cyc;
    bit          pend     [NDUT];
    int          pidx     [NDUT];
    int          resp_cyc [NDUT];
    int          next_ok  [NDUT];
    logic        exp_dv   [NDUT];
    logic [31:0] exp_do   [NDUT];
    logic        exp_err  [NDUT];
    logic [31:0] exp_io;
    logic        exp_iv;

    function automatic int lat_of(int k);
        return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
    endfunction

    function automatic logic [31:0] mm_rd(int i);
        return mm.exists(i) ? mm[i] : 32'h0;
    endfunction

    function automatic bit pattern_ok(logic [3:0] we);
        if (!ALIGN) return 1'b1;
        return we inside {4'b0001, 4'b0010, 4'b0100, 4'b1000,
                          4'b0011, 4'b0110, 4'b1100, 4'b1111};
    endfunction

    task automatic model_reset();
        cyc    = 0;
        exp_io = 32'h0;
        exp_iv = 1'b0;
        for (int k = 0; k < NDUT; k++) begin
            pend[k]    = 1'b0;
            next_ok[k] = 0;
            exp_dv[k]  = 1'b0;
            exp_do[k]  = 32'h0;
            exp_err[k] = 1'b0;
        end
    endtask

    task automatic model_update();
        int          widx;
        int          fidx;
        logic [31:0] w;
        if (!rst_n) begin
            model_reset();
            return;
        end
        cyc++;
        widx = int'(data_addr[AW+1:2]);
        fidx = int'(instr_addr[AW+1:2]);
        for (int k = 0; k < NDUT; k++) begin
            exp_dv[k] = 1'b0;
            if (pend[k]) begin
                if (cyc == resp_cyc[k]) begin
                    exp_dv[k]  = 1'b1;
                    exp_do[k]  = mm_rd(pidx[k]);
                    pend[k]    = 1'b0;
                    next_ok[k] = cyc + 1;
                end
            end else if (data_read && cyc >= next_ok[k]) begin
                if (data_write == 4'b0000) begin
                    pend[k]     = 1'b1;
                    pidx[k]     = widx;
                    resp_cyc[k] = cyc + lat_of(k);
                end else if (ALIGN) begin
                    exp_err[k] = 1'b1;
                end
            end
        end
        exp_iv = instr_read;
        if (instr_read) exp_io = mm_rd(fidx);
        if (ALIGN && instr_read && instr_addr[1:0] != 2'b00) begin
            for (int k = 0; k < NDUT; k++) exp_err[k] = 1'b1;
        end
        if (data_write != 4'b0000) begin
            if (pattern_ok(data_write)) begin
                w = mm_rd(widx);
                for (int b = 0; b < 4; b++) begin
                    if (data_write[b]) w[8*b +: 8] = data_in[8*b +: 8];
                end
                mm[widx] = w;
            end else begin
                for (int k = 0; k < NDUT; k++) exp_err[k] = 1'b1;
            end
        end
    endtask

    // Inputs change only on negedge, so the model sees exactly what the DUT sampled.
    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle(int n);
        data_read  = 1'b0;
        data_write = 4'b0000;
        instr_read = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(logic [31:0] a, logic [3:0] we, logic [31:0] d);
        data_addr  = a;
        data_write = we;
        data_in    = d;
        tick();
        data_write = 4'b0000;
    endtask

    task automatic test_reset();
        tick();
        tick();
        for (int k = 0; k < NDUT; k++) begin
            n_checks++;
            if ({io[k], iv[k], dout[k], dv[k], er[k]} !== 67'h0) begin
                n_errors++;
                $display("FAIL reset_state[%0d]: got io=%h iv=%b do=%h dv=%b err=%b, expected all 0",
                         k, io[k], iv[k], dout[k], dv[k], er[k]);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_byte_lanes();
        wr(32'h40, 4'b1111, 32'h11223344);
        wr(32'h41, 4'b0010, 32'h0000AA00);
        data_addr = 32'h40;
        data_read = 1'b1;
        tick();
        data_read = 1'b0;
        n_checks++;
        if (dv[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL lanes_early_valid: got %b, expected 0", dv[0]);
        end
        tick();
        n_checks++;
        if (dv[0] !== 1'b1 || dout[0] !== 32'h1122AA44) begin
            n_errors++;
            $display("FAIL lanes_read: got dv=%b do=%h, expected dv=1 do=1122aa44", dv[0], dout[0]);
        end
        tick();
        n_checks++;
        if (dv[0] !== 1'b0 || dout[0] !== 32'h1122AA44) begin
            n_errors++;
            $display("FAIL lanes_pulse_hold: got dv=%b do=%h, expected dv=0 do=1122aa44",
                     dv[0], dout[0]);
        end
        idle(6);
    endtask

    task automatic test_back_to_back();
        logic exp;
        wr(32'h80, 4'b1111, 32'hDEADBEEF);
        data_addr = 32'h80;
        data_read = 1'b1;
        tick();
        for (int j = 1; j <= 8; j++) begin
            tick();
            exp = (j == 3) || (j == 7);
            n_checks++;
            if (dv[1] !== exp || (exp && dout[1] !== 32'hDEADBEEF)) begin
                n_errors++;
                $display("FAIL b2b_cycle%0d: got dv=%b do=%h, expected dv=%b do=deadbeef",
                         j, dv[1], dout[1], exp);
            end
        end
        idle(8);
    endtask

    task automatic test_write_during_wait();
        wr(32'h100, 4'b1111, 32'h12345678);
        data_addr = 32'h100;
        data_read = 1'b1;
        tick();
        data_read = 1'b0;
        wr(32'h100, 4'b1111, 32'hCAFEF00D);
        n_checks++;
        if (dv[0] !== 1'b1 || dout[0] !== 32'h12345678) begin
            n_errors++;
            $display("FAIL resp_edge_write: got dv=%b do=%h, expected dv=1 do=12345678",
                     dv[0], dout[0]);
        end
        tick();
        n_checks++;
        if (dv[1] !== 1'b0) begin
            n_errors++;
            $display("FAIL wait_early_valid: got %b, expected 0", dv[1]);
        end
        tick();
        n_checks++;
        if (dv[1] !== 1'b1 || dout[1] !== 32'hCAFEF00D) begin
            n_errors++;
            $display("FAIL wait_write_l3: got dv=%b do=%h, expected dv=1 do=cafef00d",
                     dv[1], dout[1]);
        end
        tick();
        n_checks++;
        if (dv[2] !== 1'b1 || dout[2] !== 32'hCAFEF00D) begin
            n_errors++;
            $display("FAIL wait_write_l4: got dv=%b do=%h, expected dv=1 do=cafef00d",
                     dv[2], dout[2]);
        end
        idle(6);
    endtask

    task automatic test_fetch_write();
        wr(32'h200, 4'b1111, 32'h00000013);
        instr_read = 1'b1;
        instr_addr = 32'h200;
        wr(32'h200, 4'b1111, 32'h55555555);
        n_checks++;
        if (iv[0] !== 1'b1 || io[0] !== 32'h00000013) begin
            n_errors++;
            $display("FAIL fetch_prewrite: got iv=%b io=%h, expected iv=1 io=00000013", iv[0], io[0]);
        end
        tick();
        n_checks++;
        if (iv[0] !== 1'b1 || io[0] !== 32'h55555555) begin
            n_errors++;
            $display("FAIL fetch_postwrite: got iv=%b io=%h, expected iv=1 io=55555555", iv[0], io[0]);
        end
        instr_read = 1'b0;
        tick();
        n_checks++;
        if (iv[0] !== 1'b0 || io[0] !== 32'h55555555) begin
            n_errors++;
            $display("FAIL fetch_hold: got iv=%b io=%h, expected iv=0 io=55555555", iv[0], io[0]);
        end
        idle(2);
    endtask

    task automatic test_alias_and_align();
        logic [31:0] exp_word;
        wr(32'h0000_0004, 4'b1111, 32'h00000001);
        data_addr = 32'h0001_0004;
        data_read = 1'b1;
        tick();
        data_read = 1'b0;
        tick();
        n_checks++;
        if (dv[0] !== 1'b1 || dout[0] !== 32'h00000001) begin
            n_errors++;
            $display("FAIL alias_read: got dv=%b do=%h, expected dv=1 do=00000001", dv[0], dout[0]);
        end
        idle(5);
        n_checks++;
        if (er[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL err_clean: got %b, expected 0", er[0]);
        end
        wr(32'h4, 4'b0101, 32'hFFFFFFFF);
        n_checks++;
        if (er[0] !== ALIGN) begin
            n_errors++;
            $display("FAIL err_set: got %b, expected %b", er[0], ALIGN);
        end
        exp_word = ALIGN ? 32'h00000001 : 32'h00FF00FF;
        data_addr = 32'h4;
        data_read = 1'b1;
        tick();
        data_read = 1'b0;
        tick();
        n_checks++;
        if (dout[0] !== exp_word || er[0] !== ALIGN) begin
            n_errors++;
            $display("FAIL illegal_write_word: got do=%h err=%b, expected do=%h err=%b",
                     dout[0], er[0], exp_word, ALIGN);
        end
        idle(5);
    endtask

    task automatic test_reset_mid_read();
        wr(32'h300, 4'b1111, 32'hA5A5A5A5);
        data_addr = 32'h300;
        data_read = 1'b1;
        tick();
        data_read = 1'b0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < NDUT; k++) begin
            n_checks++;
            if ({io[k], iv[k], dout[k], dv[k], er[k]} !== 67'h0) begin
                n_errors++;
                $display("FAIL midreset_state[%0d]: got io=%h iv=%b do=%h dv=%b err=%b, expected 0",
                         k, io[k], iv[k], dout[k], dv[k], er[k]);
            end
        end
        tick();
        rst_n = 1'b1;
        for (int j = 0; j < 8; j++) begin
            tick();
            n_checks++;
            if (dv[2] !== 1'b0) begin
                n_errors++;
                $display("FAIL midreset_ghost_valid: got %b, expected 0", dv[2]);
            end
        end
        data_read = 1'b1;
        tick();
        data_read = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            tick();
            n_checks++;
            if (dv[2] !== (j == 4) || (j == 4 && dout[2] !== 32'hA5A5A5A5)) begin
                n_errors++;
                $display("FAIL midreset_restart%0d: got dv=%b do=%h, expected dv=%b do=a5a5a5a5",
                         j, dv[2], dout[2], (j == 4));
            end
        end
        idle(6);
    endtask

    task automatic test_random();
        logic [3:0] legal [8];
        legal = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b0110, 4'b1100, 4'b1111};
        for (int i = 0; i < 16; i++) wr(32'(i * 4), 4'b1111, $urandom);
        for (int i = 0; i < 400; i++) begin
            data_read  = ($urandom % 5) < 2;
            data_addr  = {16'($urandom), 10'h0, 4'($urandom), 2'($urandom)};
            data_in    = $urandom;
            if ($urandom % 2 == 0) data_write = 4'b0000;
            else if ($urandom % 10 != 0) data_write = legal[$urandom % 8];
            else data_write = 4'($urandom_range(1, 15));
            instr_read = $urandom % 2 == 0;
            instr_addr = {16'($urandom), 10'h0, 4'($urandom),
                          ($urandom % 8 == 0) ? 2'($urandom) : 2'b00};
            tick();
            for (int k = 0; k < NDUT; k++) begin
                n_checks++;
                if (dv[k] !== exp_dv[k] || dout[k] !== exp_do[k] || er[k] !== exp_err[k] ||
                    iv[k] !== exp_iv || io[k] !== exp_io) begin
                    n_errors++;
                    $display("FAIL random[%0d] dut%0d: got dv=%b do=%h err=%b iv=%b io=%h, expected dv=%b do=%h err=%b iv=%b io=%h",
                             i, k, dv[k], dout[k], er[k], iv[k], io[k],
                             exp_dv[k], exp_do[k], exp_err[k], exp_iv, exp_io);
                end
            end
        end
        idle(6);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst_n      = 1'b0;
        instr_read = 1'b0;
        instr_addr = 32'h0;
        data_read  = 1'b0;
        data_addr  = 32'h0;
        data_write = 4'b0000;
        data_in    = 32'h0;
        model_reset();
        test_reset();
        test_byte_lanes();
        test_back_to_back();
        test_write_during_wait();
        test_fetch_write();
        test_alias_and_align();
        test_reset_mid_read();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Unified instruction/data memory responder: the memory-side end of the CPU fetch and load/store interface.
- Serves instruction fetches with fixed 1-cycle latency.
- Serves data reads through a latency FSM with configurable wait states, and applies byte-lane writes.
- Samples on posedge clk; the CPU drives requests on negedge, so requests are stable half a cycle before sampling.

Parameters:
ADDR_WIDTH, 14, word-address bits; array depth = 2**ADDR_WIDTH 32-bit words
READ_LATENCY, 1, data-read latency in cycles from request sample to data_valid; legal range 1..15

Ports:
clk  input  1  clock, posedge active
rst  input  1  asynchronous active-low reset
instr_read  input  1  fetch request
instr_addr  input  32  fetch byte address
instr_out  output  32  fetched word
instr_valid  output  1  instr_out updated this cycle
data_read  input  1  load request
data_addr  input  32  load/store byte address
data_write  input  4  byte-lane write enables, bit i = data_in[8i+7:8i]
data_in  input  32  store data, already lane-shifted by the CPU
data_out  output  32  loaded word (full word; CPU extracts byte/half)
data_valid  output  1  one-cycle pulse, data_out newly loaded
err  output  1  sticky protocol error (MEM_ALIGN_CHECK_EN only, else tied 0)

Behaviour:
- Word index = addr[ADDR_WIDTH+1:2] for both ports. Upper bits are ignored: addresses alias/wrap modulo 4*2**ADDR_WIDTH. addr[1:0] are ignored for indexing.
- Reset (rst=0, async): instr_out=0, instr_valid=0, data_out=0, data_valid=0, err=0, FSM=D_IDLE, wait counter=0. Array contents are not reset.
- Reset mid-operation drops any pending read; no data_valid is produced after release.
- Write: on posedge with data_write!=0, each lane i with data_write[i]=1 is written; other lanes are unchanged. Write completes in 1 cycle with no response pulse.
- Fetch: on posedge with instr_read=1, instr_out<=mem[iidx] and instr_valid<=1; otherwise instr_valid<=0 and instr_out holds.
- Same-cycle fetch and write to the same word: fetch returns the pre-write word.
- Data FSM, 4-bit counter cnt:
  - D_IDLE: if data_read=1 and data_write=0, latch index. If READ_LATENCY=1 go to D_RESP; else cnt<=READ_LATENCY-2 and go to D_WAIT.
  - D_WAIT: if cnt=0 go to D_RESP, else cnt<=cnt-1. data_read, data_addr and new requests are ignored (no queueing).
  - D_RESP: data_out<=mem[latched index], data_valid<=1 for exactly one cycle, go to D_IDLE.
  - data_valid rises READ_LATENCY cycles after the sampling edge.
  - The response reflects the array at the D_RESP edge: a write landing during D_WAIT to the same word is visible; a write on the D_RESP edge itself is not.
- data_read=1 with data_write!=0 in the same cycle: the write is performed and the read is ignored.
- data_read held high across D_RESP: a new read starts on the first edge back in D_IDLE, i.e. back-to-back reads every READ_LATENCY+1 cycles.
- data_out holds its last value between responses.

Optional Feature:
MEM_ALIGN_CHECK_EN
- Defined: err is set (sticky until reset) in these cases:
  - data_write is not one of 0001,0010,0100,1000,0011,0110,1100,1111 and is nonzero; that write is suppressed entirely.
  - instr_read=1 with instr_addr[1:0]!=0; the fetch still proceeds.
  - data_read=1 accepted in D_IDLE while data_write!=0.
- Undefined: no checking; every nonzero pattern is written lane-wise; err is constant 0.

Test Plan:
- Reset: assert rst=0 mid-D_WAIT (READ_LATENCY=4) -> all outputs 0 immediately, no data_valid after release, FSM in D_IDLE.
- Write 0x11223344 to 0x40 with data_write=1111; write data_in=0x0000AA00 with 0010 to 0x41; read 0x40 -> data_out=0x1122AA44, data_valid single pulse 1 cycle after request (READ_LATENCY=1).
- READ_LATENCY=3, data_read held high at 0x80 containing 0xDEADBEEF -> data_valid pulses at cycles 3 and 7 after first sample, data_out=0xDEADBEEF both times.
- READ_LATENCY=3: read 0x100, write 0xCAFEF00D to 0x100 during D_WAIT -> data_out=0xCAFEF00D.
- Fetch 0x200 same cycle as write 0x55555555 there (old 0x00000013) -> instr_out=0x00000013, next fetch returns 0x55555555.
- Aliasing with ADDR_WIDTH=14: write 0x0000_0004 = 0x1, read 0x0001_0004 -> 0x1. With MEM_ALIGN_CHECK_EN: data_write=0101 -> word unchanged, err=1 until reset.
